// File: rtl/counter_decoder_param.sv
// counter_decoder_param: up/down modulo-(MAX_COUNT+1) counter with a RUN/HOLD
// control FSM, synchronous clamped load, registered wrap pulse and an equality
// decode of the count against MATCH.
// Optional feature: define COUNTER_DECODER_ONEHOT_EN to add the one-hot
// decode output dec_out (bit[count_out] high).
module counter_decoder_param #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 9,
  parameter int MATCH     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stop,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             out,
  output logic             wrap,
  output logic             holding
`ifdef COUNTER_DECODER_ONEHOT_EN
  ,
  output logic [MAX_COUNT:0] dec_out
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] MaxC   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MatchC = WIDTH'(MATCH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  // Next-state logic: FSM follows stop; load overrides counting; wrap marks modulo crossings.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d = stop ? HOLD : RUN;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_val > MaxC) ? MaxC : load_val;
    end else if (state_q == RUN && !stop) begin
      if (dir) begin
        // >= keeps the counter inside range even if it were ever out of it.
        if (count_q >= MaxC) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = MaxC;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // State, count and wrap registers; reset is asynchronous and forces RUN at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values, independent of statement order.
    if (!rst_n) begin
      state_q <= RUN;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Outputs are decoded from registers only, so no input reaches them combinationally.
  assign count_out = count_q;
  assign wrap      = wrap_q;
  assign holding   = (state_q == HOLD);
  assign out       = (count_q == MatchC);

`ifdef COUNTER_DECODER_ONEHOT_EN
  // One-hot decode of the current count.
  assign dec_out = {{MAX_COUNT{1'b0}}, 1'b1} << count_q;
`endif

endmodule

// File: tb/tb_counter_decoder_param.sv
// Self-checking bench for counter_decoder_param: directed scenarios followed by
// randomized stimulus, all compared against a behavioural model of the counter.
// Compile with COUNTER_DECODER_ONEHOT_EN defined to also check dec_out.
module tb_counter_decoder_param;

  localparam int WIDTH     = 4;
  localparam int MAX_COUNT = 9;
  localparam int MATCH     = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stop;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_out;
  logic             out;
  logic             wrap;
  logic             holding;
`ifdef COUNTER_DECODER_ONEHOT_EN
  logic [MAX_COUNT:0] dec_out;
`endif

  counter_decoder_param #(
    .WIDTH    (WIDTH),
    .MAX_COUNT(MAX_COUNT),
    .MATCH    (MATCH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stop     (stop),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .count_out(count_out),
    .out      (out),
    .wrap     (wrap),
    .holding  (holding)
`ifdef COUNTER_DECODER_ONEHOT_EN
    ,
    .dec_out  (dec_out)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: count as an integer in 0..MAX_COUNT, hold flag, wrap flag.
  int m_cnt;
  bit m_hold;
  bit m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count_out), 32'(m_cnt));
    check({tag, ".out"}, 32'(out), 32'(m_cnt == MATCH));
    check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    check({tag, ".holding"}, 32'(holding), 32'(m_hold));
`ifdef COUNTER_DECODER_ONEHOT_EN
    check({tag, ".dec"}, 32'(dec_out), 32'(1) << m_cnt);
`endif
  endtask

  // Advance the model by one edge using the inputs that were applied before it.
  task automatic model_edge();
    bit counting;
    counting = !m_hold && !stop;
    m_wrap   = 1'b0;
    if (load) begin
      m_cnt = (int'(load_val) > MAX_COUNT) ? MAX_COUNT : int'(load_val);
    end else if (counting) begin
      if (dir) begin
        m_wrap = (m_cnt == MAX_COUNT);
        m_cnt  = (m_cnt + 1) % (MAX_COUNT + 1);
      end else begin
        m_wrap = (m_cnt == 0);
        m_cnt  = (m_cnt + MAX_COUNT) % (MAX_COUNT + 1);
      end
    end
    m_hold = stop;
  endtask

  // Apply inputs, take one rising edge, then compare 1 time unit later.
  task automatic step(input string tag, input bit s, input bit d, input bit l, input int lv);
    stop     = s;
    dir      = d;
    load     = l;
    load_val = WIDTH'(lv);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between edges; checked before any edge.
  task automatic pulse_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    m_cnt  = 0;
    m_hold = 1'b0;
    m_wrap = 1'b0;
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_up[12];
    rst_n    = 1'b1;
    stop     = 1'b0;
    dir      = 1'b1;
    load     = 1'b0;
    load_val = '0;

    // Reset state.
    pulse_reset("reset");

    // Count up 12 edges from reset: 1..9,0,1,2.
    exp_up = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    for (int i = 0; i < 12; i++) begin
      step("up", 1'b0, 1'b1, 1'b0, 0);
      check("up.seq", 32'(count_out), 32'(exp_up[i]));
    end

    // Hold at 3 for 4 edges, then one resume edge at 3, then 4.
    pulse_reset("rst2");
    for (int i = 0; i < 3; i++) step("to3", 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      step("hold", 1'b1, 1'b1, 1'b0, 0);
      check("hold.cnt", 32'(count_out), 32'd3);
    end
    step("resume", 1'b0, 1'b1, 1'b0, 0);
    check("resume.cnt", 32'(count_out), 32'd3);
    check("resume.hold", 32'(holding), 32'd0);
    step("resume2", 1'b0, 1'b1, 1'b0, 0);
    check("resume2.cnt", 32'(count_out), 32'd4);

    // Count down from reset: 9,8,...,0,9.
    pulse_reset("rst3");
    for (int i = 0; i < 11; i++) step("down", 1'b0, 1'b0, 1'b0, 0);
    check("down.end", 32'(count_out), 32'd9);

    // Load above range while holding: clamps to MAX_COUNT, stays in HOLD.
    step("pre_load", 1'b1, 1'b1, 1'b0, 0);
    step("load_clamp", 1'b1, 1'b1, 1'b1, 12);
    check("clamp.cnt", 32'(count_out), 32'(MAX_COUNT));
    check("clamp.hold", 32'(holding), 32'd1);

    // Reset mid-count at 7, then the first edge counts from 0.
    pulse_reset("rst4");
    for (int i = 0; i < 7; i++) step("to7", 1'b0, 1'b1, 1'b0, 0);
    check("at7", 32'(count_out), 32'd7);
    pulse_reset("rst_mid");
    step("after_rst", 1'b0, 1'b1, 1'b0, 0);

    // Randomized run with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset("rand_rst");
      step("rand", ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_decoder_param.md
COUNTER_DECODER_PARAM -- requirements
Module: counter_decoder_param

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter MAX_COUNT, default 9: terminal count; SHALL satisfy 1 <= MAX_COUNT <= 2^WIDTH-1.
REQ-003 Parameter MATCH, default 5: decode value for out; SHALL satisfy MATCH <= MAX_COUNT.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 stop  input  1  1 = request hold, 0 = request run.
REQ-007 dir  input  1  count direction: 1 = up, 0 = down.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value loaded when load=1.
REQ-010 count_out  output  WIDTH  current count, registered.
REQ-011 out  output  1  high exactly while count_out == MATCH.
REQ-012 wrap  output  1  registered one-cycle pulse on terminal wrap.
REQ-013 holding  output  1  high while FSM is in HOLD.

Function
REQ-014 FSM SHALL have two states: RUN (holding=0), HOLD (holding=1).
REQ-015 RUN, stop=0, load=0: each edge count advances by one in direction dir.
REQ-016 Up wrap: count MAX_COUNT -> 0 and wrap=1 for that cycle; down wrap: 0 -> MAX_COUNT and wrap=1.
REQ-017 wrap SHALL be 0 in every cycle not immediately following a wrap edge.
REQ-018 RUN, stop=1 at edge: go to HOLD; count unchanged on that edge.
REQ-019 HOLD, stop=1: count and state held, wrap=0.
REQ-020 HOLD, stop=0 at edge: go to RUN; count unchanged on that edge; counting resumes on the following edge (one-cycle resume latency).
REQ-021 load=1 SHALL take priority over counting and stop: count <= load_val, or MAX_COUNT if load_val > MAX_COUNT (clamp); wrap=0.
REQ-022 load SHALL NOT change FSM state; stop is still evaluated for the state transition on the same edge.
REQ-023 out SHALL be derived from the count register only (no input-to-output combinational path).
REQ-024 dir change SHALL take effect on the next counting edge; no extra latency.
REQ-025 Count values SHALL never exceed MAX_COUNT under any input sequence.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force state RUN, count_out=0, wrap=0, holding=0, out=(MATCH==0).
REQ-027 Reset asserted mid-count or in HOLD SHALL discard all state; first edge after rst_n rises counts from 0 if stop=0.

Configuration
REQ-028 Macro COUNTER_DECODER_ONEHOT_EN defined: adds output dec_out, width MAX_COUNT+1, with exactly bit[count_out] high; reset value 1 in bit 0.
REQ-029 Macro undefined: dec_out port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Defaults, stop=0, dir=1, 12 edges after reset -> count_out 1..9,0,1,2; wrap=1 only in the cycle count_out=0; out=1 only while count_out=5.
REQ-031 stop=1 at count 3 for 4 edges, then stop=0 -> count stays 3 with holding=1, then one further edge at 3 with holding=0, then 4.
REQ-032 dir=0 from reset -> count_out 9,8,...,0,9 with wrap=1 in each cycle count_out becomes 9.
REQ-033 load=1, load_val=12 while stop=1 -> count_out=9 (clamped), holding stays 1, wrap=0.
REQ-034 rst_n pulsed low between edges at count 7 -> count_out=0, holding=0 immediately, before the next clk edge.
REQ-035 COUNTER_DECODER_ONEHOT_EN defined, count sweep 0..9 -> dec_out = 1<<count_out every cycle; macro undefined -> build without dec_out passes REQ-030.
